// File: rtl/axil_write_master.sv
// axil_write_master
//   AXI-Lite write initiator (AW/W/B only). Buffers address/data/strobe write
//   requests in a small FIFO and issues them one at a time, waiting for each
//   write response before starting the next. Non-OKAY responses are counted
//   in a saturating error counter.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   req_*               request push interface (valid/ready)
//   busy                FIFO non-empty or a write in flight
//   err_count           saturating count of non-OKAY write responses
//   axil_aw* / axil_w* / axil_b*   AXI-Lite write channels
//
// Optional build macro
//   AXIL_WRITE_MASTER_TIMEOUT_EN : adds a 16-bit watchdog that drops a
//   transaction stalled for 16'hFFFF cycles and counts it as an error.
module axil_write_master #(
  parameter int unsigned ADDR_WIDTH = 24,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ERR_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [STRB_WIDTH-1:0] req_strb,
  input  logic                  req_valid,
  output logic                  req_ready,
  output logic                  busy,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] axil_awaddr,
  output logic [2:0]            axil_awprot,
  output logic                  axil_awvalid,
  input  logic                  axil_awready,
  output logic [DATA_WIDTH-1:0] axil_wdata,
  output logic [STRB_WIDTH-1:0] axil_wstrb,
  output logic                  axil_wvalid,
  input  logic                  axil_wready,
  input  logic [1:0]            axil_bresp,
  input  logic                  axil_bvalid,
  output logic                  axil_bready
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned PTR_LEN = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ADDR_DATA = 2'd1,
    S_RESP      = 2'd2
  } state_t;

  state_t state;

  logic [ADDR_WIDTH-1:0] fifo_addr [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [DEPTH];
  logic [STRB_WIDTH-1:0] fifo_strb [DEPTH];
  logic [PTR_LEN-1:0]    wr_ptr;
  logic [PTR_LEN-1:0]    rd_ptr;

  logic init_done;
  logic aw_done;
  logic w_done;

  logic empty;
  logic full;
  logic accept;
  logic bypass;
  logic push;
  logic pop;
  logic aw_hs;
  logic w_hs;
  logic b_hs;

  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [STRB_WIDTH-1:0] ld_strb;
  logic [ERR_WIDTH-1:0]  err_next;

  // FIFO status from the wrap-bit pointers
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  // init_done keeps req_ready low until the first edge after reset release
  assign req_ready = init_done && !full;
  assign accept    = req_valid && req_ready;

  assign aw_hs = axil_awvalid && axil_awready;
  assign w_hs  = axil_wvalid && axil_wready;
  assign b_hs  = axil_bready && axil_bvalid;

  // An idle block with an empty FIFO launches the incoming request directly,
  // giving valids one cycle after acceptance.
  assign bypass = accept && empty && (state == S_IDLE);
  assign push   = accept && !bypass;
  assign pop    = !empty && ((state == S_IDLE) || ((state == S_RESP) && b_hs));

  assign ld_addr = bypass ? req_addr : fifo_addr[rd_ptr[PTR_W-1:0]];
  assign ld_data = bypass ? req_data : fifo_data[rd_ptr[PTR_W-1:0]];
  assign ld_strb = bypass ? req_strb : fifo_strb[rd_ptr[PTR_W-1:0]];

  assign err_next = (err_count == '1) ? err_count : err_count + ERR_WIDTH'(1);

  assign busy        = !empty || (state != S_IDLE);
  assign axil_awprot = 3'b000;

`ifdef AXIL_WRITE_MASTER_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        tmo_fire;

  // Watchdog fires only on a cycle with no handshake at all
  assign tmo_fire = (state != S_IDLE) && (tmo_cnt == 16'hFFFF) &&
                    !(aw_hs || w_hs || b_hs);
`endif

  // FIFO storage (no reset needed, pointers qualify contents)
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr[PTR_W-1:0]] <= req_addr;
      fifo_data[wr_ptr[PTR_W-1:0]] <= req_data;
      fifo_strb[wr_ptr[PTR_W-1:0]] <= req_strb;
    end
  end

  // Control FSM, pointers and registered AXI outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      init_done    <= 1'b0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      err_count    <= '0;
      axil_awaddr  <= '0;
      axil_wdata   <= '0;
      axil_wstrb   <= '0;
      axil_awvalid <= 1'b0;
      axil_wvalid  <= 1'b0;
      axil_bready  <= 1'b0;
`ifdef AXIL_WRITE_MASTER_TIMEOUT_EN
      tmo_cnt      <= '0;
`endif
    end else begin
      init_done <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_LEN'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_LEN'(1);

      unique case (state)
        S_IDLE: begin
          if (pop || bypass) begin
            axil_awaddr  <= ld_addr;
            axil_wdata   <= ld_data;
            axil_wstrb   <= ld_strb;
            axil_awvalid <= 1'b1;
            axil_wvalid  <= 1'b1;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            state        <= S_ADDR_DATA;
          end
        end

        S_ADDR_DATA: begin
          if (aw_hs) axil_awvalid <= 1'b0;
          if (w_hs)  axil_wvalid  <= 1'b0;
          aw_done <= aw_done || aw_hs;
          w_done  <= w_done || w_hs;
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            axil_bready <= 1'b1;
            state       <= S_RESP;
          end
        end

        S_RESP: begin
          if (b_hs) begin
            axil_bready <= 1'b0;
            if (axil_bresp != 2'b00) err_count <= err_next;
            if (pop) begin
              axil_awaddr  <= ld_addr;
              axil_wdata   <= ld_data;
              axil_wstrb   <= ld_strb;
              axil_awvalid <= 1'b1;
              axil_wvalid  <= 1'b1;
              aw_done      <= 1'b0;
              w_done       <= 1'b0;
              state        <= S_ADDR_DATA;
            end else begin
              state <= S_IDLE;
            end
          end
        end

        default: state <= S_IDLE;
      endcase

`ifdef AXIL_WRITE_MASTER_TIMEOUT_EN
      // Stalled transaction: abandon it and count it as an error
      if (state == S_IDLE || aw_hs || w_hs || b_hs) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
      if (tmo_fire) begin
        axil_awvalid <= 1'b0;
        axil_wvalid  <= 1'b0;
        axil_bready  <= 1'b0;
        err_count    <= err_next;
        tmo_cnt      <= '0;
        state        <= S_IDLE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_axil_write_master.sv
// tb_axil_write_master
//   Drives directed and randomized request/AXI traffic into axil_write_master
//   and compares every cycle against a transaction-level model built from a
//   request queue, the current write and its outstanding AW/W/B phases.
module tb_axil_write_master;

  localparam int unsigned AW      = 24;
  localparam int unsigned DW      = 32;
  localparam int unsigned SW      = 4;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned EW      = 2;
  localparam int          ERR_MAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic [SW-1:0] req_strb;
  logic          req_valid;
  logic          req_ready;
  logic          busy;
  logic [EW-1:0] err_count;
  logic [AW-1:0] axil_awaddr;
  logic [2:0]    axil_awprot;
  logic          axil_awvalid;
  logic          axil_awready;
  logic [DW-1:0] axil_wdata;
  logic [SW-1:0] axil_wstrb;
  logic          axil_wvalid;
  logic          axil_wready;
  logic [1:0]    axil_bresp;
  logic          axil_bvalid;
  logic          axil_bready;

  axil_write_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .DEPTH(DEPTH), .ERR_WIDTH(EW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb),
    .req_valid(req_valid), .req_ready(req_ready),
    .busy(busy), .err_count(err_count),
    .axil_awaddr(axil_awaddr), .axil_awprot(axil_awprot),
    .axil_awvalid(axil_awvalid), .axil_awready(axil_awready),
    .axil_wdata(axil_wdata), .axil_wstrb(axil_wstrb),
    .axil_wvalid(axil_wvalid), .axil_wready(axil_wready),
    .axil_bresp(axil_bresp), .axil_bvalid(axil_bvalid), .axil_bready(axil_bready)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
  } req_t;

  // Transaction-level model state
  req_t          q[$];
  req_t          cur;
  int            phase;      // 0 idle, 1 address/data outstanding, 2 awaiting B
  bit            m_aw;
  bit            m_w;
  int            m_err;
  bit            m_rdy;
  logic [AW-1:0] aw_log[$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    phase = 0;
    m_aw  = 1'b0;
    m_w   = 1'b0;
    m_err = 0;
    m_rdy = 1'b0;
  endfunction

  function automatic void start(req_t r);
    cur   = r;
    m_aw  = 1'b1;
    m_w   = 1'b1;
    phase = 1;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge
  function automatic void model_step();
    req_t r;
    bit   push;
    if (!rst) begin
      model_reset();
      return;
    end
    r.a  = req_addr;
    r.d  = req_data;
    r.s  = req_strb;
    push = req_valid && m_rdy && (q.size() < DEPTH);
    case (phase)
      0: begin
        if (q.size() != 0) begin
          start(q.pop_front());
        end else if (push) begin
          start(r);
          push = 1'b0;
        end
      end
      1: begin
        if (m_aw && axil_awready) begin
          m_aw = 1'b0;
          aw_log.push_back(cur.a);
        end
        if (m_w && axil_wready) m_w = 1'b0;
        if (!m_aw && !m_w) phase = 2;
      end
      default: begin
        if (axil_bvalid) begin
          if (axil_bresp != 2'b00 && m_err < ERR_MAX) m_err++;
          if (q.size() != 0) start(q.pop_front());
          else phase = 0;
        end
      end
    endcase
    if (push) q.push_back(r);
    m_rdy = 1'b1;
  endfunction

  function automatic void compare();
    chk("awvalid", 64'(axil_awvalid), 64'(m_aw));
    chk("wvalid", 64'(axil_wvalid), 64'(m_w));
    chk("bready", 64'(axil_bready), 64'(phase == 2));
    chk("busy", 64'(busy), 64'(q.size() != 0 || phase != 0));
    chk("req_ready", 64'(req_ready), 64'(m_rdy && q.size() < DEPTH));
    chk("err_count", 64'(err_count), 64'(m_err));
    chk("awprot", 64'(axil_awprot), 64'(0));
    if (m_aw) chk("awaddr", 64'(axil_awaddr), 64'(cur.a));
    if (m_w) begin
      chk("wdata", 64'(axil_wdata), 64'(cur.d));
      chk("wstrb", 64'(axil_wstrb), 64'(cur.s));
    end
  endfunction

  // One clock: model follows the edge, outputs checked on the falling edge
  task automatic cycle(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
    end
  endtask

  task automatic quiet_inputs();
    req_valid    = 1'b0;
    req_addr     = '0;
    req_data     = '0;
    req_strb     = '0;
    axil_awready = 1'b0;
    axil_wready  = 1'b0;
    axil_bvalid  = 1'b0;
    axil_bresp   = 2'b00;
  endtask

  task automatic set_req(logic [AW-1:0] a, logic [DW-1:0] d, logic [SW-1:0] s);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_strb  = s;
  endtask

  logic [AW-1:0] exp_a;
  int            exp_e;

  initial begin
    quiet_inputs();
    model_reset();
    rst = 1'b1;
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_awvalid", 64'(axil_awvalid), 64'(0));
    chk("rst_wvalid", 64'(axil_wvalid), 64'(0));
    chk("rst_bready", 64'(axil_bready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(err_count), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_awaddr", 64'(axil_awaddr), 64'(0));
    chk("rst_wdata", 64'(axil_wdata), 64'(0));
    chk("rst_wstrb", 64'(axil_wstrb), 64'(0));
    cycle(1);
    rst = 1'b1;
    cycle(1);
    chk("rel_req_ready", 64'(req_ready), 64'(1));

    // Single write with immediate readies and B one cycle later
    set_req(24'h000040, 32'h00000ABC, 4'hF);
    axil_awready = 1'b1;
    axil_wready  = 1'b1;
    cycle(1);
    req_valid = 1'b0;
    chk("single_awvalid", 64'(axil_awvalid), 64'(1));
    chk("single_awaddr", 64'(axil_awaddr), 64'(24'h000040));
    chk("single_wdata", 64'(axil_wdata), 64'(32'h00000ABC));
    chk("single_wstrb", 64'(axil_wstrb), 64'(4'hF));
    axil_bvalid = 1'b1;
    cycle(1);
    chk("single_aw_drop", 64'(axil_awvalid), 64'(0));
    chk("single_bready", 64'(axil_bready), 64'(1));
    cycle(1);
    chk("single_bready_drop", 64'(axil_bready), 64'(0));
    chk("single_busy", 64'(busy), 64'(0));
    chk("single_err", 64'(err_count), 64'(0));
    axil_bvalid = 1'b0;

    // Split handshake: W held off for 3 cycles
    set_req(24'h000100, 32'h12345678, 4'h5);
    axil_awready = 1'b1;
    axil_wready  = 1'b0;
    cycle(1);
    req_valid = 1'b0;
    cycle(1);
    chk("split_aw_drop", 64'(axil_awvalid), 64'(0));
    chk("split_wvalid", 64'(axil_wvalid), 64'(1));
    cycle(2);
    chk("split_wdata", 64'(axil_wdata), 64'(32'h12345678));
    chk("split_no_resp", 64'(axil_bready), 64'(0));
    axil_wready = 1'b1;
    cycle(1);
    chk("split_resp", 64'(axil_bready), 64'(1));
    axil_bvalid = 1'b1;
    cycle(1);
    axil_bvalid = 1'b0;

    // Backpressure: AW stalled while six requests are offered
    aw_log.delete();
    axil_awready = 1'b0;
    axil_wready  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_req(24'(i * 4), 32'(32'hA000 + i), 4'hF);
      if (i == 5) chk("full_req_ready", 64'(req_ready), 64'(0));
      cycle(1);
    end
    req_valid    = 1'b0;
    axil_awready = 1'b1;
    axil_bvalid  = 1'b1;
    cycle(15);
    chk("order_count", 64'(aw_log.size()), 64'(5));
    for (int i = 0; i < 5 && i < aw_log.size(); i++) begin
      exp_a = 24'(i * 4);
      chk("order_addr", 64'(aw_log[i]), 64'(exp_a));
    end
    chk("order_idle", 64'(busy), 64'(0));

    // Error responses: three SLVERR, one OKAY, two more SLVERR (saturation)
    for (int k = 0; k < 6; k++) begin
      axil_bresp = (k == 3) ? 2'b00 : 2'b10;
      set_req(24'(24'h200 + k * 4), 32'(k), 4'h3);
      cycle(1);
      req_valid = 1'b0;
      cycle(3);
      exp_e = (k < 3) ? k + 1 : 3;
      chk("err_literal", 64'(err_count), 64'(exp_e));
    end
    axil_bresp  = 2'b00;
    axil_bvalid = 1'b0;

    // Asynchronous reset in the middle of ADDR_DATA with two requests queued
    axil_awready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(24'(24'h300 + i * 4), 32'(i), 4'hF);
      cycle(1);
    end
    req_valid = 1'b0;
    #5 rst = 1'b0;
    #1;
    chk("arst_awvalid", 64'(axil_awvalid), 64'(0));
    chk("arst_wvalid", 64'(axil_wvalid), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_err", 64'(err_count), 64'(0));
    cycle(2);
    rst = 1'b1;
    aw_log.delete();
    axil_awready = 1'b1;
    axil_wready  = 1'b1;
    axil_bvalid  = 1'b1;
    cycle(10);
    chk("arst_no_replay", 64'(aw_log.size()), 64'(0));
    set_req(24'h000444, 32'hCAFEF00D, 4'hC);
    cycle(1);
    req_valid = 1'b0;
    chk("arst_new_addr", 64'(axil_awaddr), 64'(24'h000444));
    cycle(4);

    // Randomized traffic in segments separated by a short reset
    for (int seg = 0; seg < 4; seg++) begin
      quiet_inputs();
      rst = 1'b0;
      cycle(2);
      rst = 1'b1;
      for (int c = 0; c < 700; c++) begin
        req_valid    = ($urandom_range(0, 1) == 1);
        req_addr     = AW'($urandom);
        req_data     = $urandom;
        req_strb     = SW'($urandom);
        axil_awready = ($urandom_range(0, 3) != 0) || (seg == 1 && c > 400);
        axil_wready  = ($urandom_range(0, 3) != 0);
        axil_bvalid  = ($urandom_range(0, 2) != 0);
        axil_bresp   = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        cycle(1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_write_master.md
Name: axil_write_master

Overview:
- AXI-Lite write initiator that drives the GPU's AXI-Lite write slave port (AW/W/B channels only) from the CPU/loader side.
- Accepts simple address/data/strobe write requests and buffers them in a small FIFO.
- Issues one AXI-Lite write at a time and waits for each write response before the next.
- Counts error responses so firmware can detect bad GPU writes, for example out-of-range cluster addresses.

Parameters:
- ADDR_WIDTH, 24, AXI-Lite address width.
- DATA_WIDTH, 32, AXI-Lite data width.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.
- DEPTH, 4, request FIFO depth; power of two, at least 2.
- ERR_WIDTH, 8, error counter width.

Ports:
- clk  input  1  system clock (50 MHz).
- rst  input  1  asynchronous, active-low reset.
- req_addr  input  ADDR_WIDTH  request byte address.
- req_data  input  DATA_WIDTH  request write data.
- req_strb  input  STRB_WIDTH  request byte strobes.
- req_valid  input  1  request valid.
- req_ready  output  1  request accepted when req_valid && req_ready.
- busy  output  1  FIFO non-empty or transaction in flight.
- err_count  output  ERR_WIDTH  saturating count of non-OKAY responses.
- axil_awaddr  output  ADDR_WIDTH  write address.
- axil_awprot  output  3  constant 3'b000.
- axil_awvalid  output  1  address valid.
- axil_awready  input  1  address ready.
- axil_wdata  output  DATA_WIDTH  write data.
- axil_wstrb  output  STRB_WIDTH  write strobes.
- axil_wvalid  output  1  data valid.
- axil_wready  input  1  data ready.
- axil_bresp  input  2  write response.
- axil_bvalid  input  1  response valid.
- axil_bready  output  1  response ready.

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO flushed; state IDLE.
  - awvalid, wvalid, bready, busy, err_count all 0.
  - awaddr, wdata, wstrb are 0.
  - req_ready is 0 while reset is asserted and 1 from the first cycle after release.
- Reset mid-transaction: the transaction is abandoned, nothing is replayed, and all buffered requests are lost.
- FIFO:
  - req_ready = !full.
  - Push on req_valid && req_ready.
  - When full, no push is allowed even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full both take effect.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally.
- States:
  - IDLE: if FIFO non-empty, pop the head into the output registers, set awvalid=wvalid=1, and go to ADDR_DATA.
  - ADDR_DATA:
    - awvalid drops in the cycle after the AW handshake; wvalid drops in the cycle after the W handshake. The two may complete in either order or in the same cycle.
    - When both have completed (tracked with aw_done/w_done flags), go to RESP with bready=1.
    - awvalid and wvalid never drop before their handshake.
    - awaddr, wdata and wstrb are stable while their valid is high.
  - RESP:
    - bready=1. On bvalid, bready drops next cycle.
    - If bresp != 2'b00, err_count increments, saturating at all-ones.
    - Then, if the FIFO is non-empty, pop and go directly to ADDR_DATA; otherwise go to IDLE.
- Latency:
  - Request accepted in cycle N into an empty idle block: awvalid/wvalid are high in cycle N+1.
  - Best-case throughput is one write per 2 cycles: AW+W in one cycle, B in the next.
- Ordering: exactly one outstanding write and strict FIFO order. B is never accepted outside RESP.
- busy = (FIFO non-empty) || (state != IDLE). It is registered-output equivalent and glitch-free.

Optional Feature:
- Macro AXIL_WRITE_MASTER_TIMEOUT_EN.
- When defined:
  - A 16-bit counter runs in ADDR_DATA and RESP and clears on every handshake.
  - When it reaches 16'hFFFF, the transaction is dropped: valids and bready are deasserted, err_count increments, and the state goes to IDLE.
- When undefined: no counter exists and the block waits indefinitely.

Test Plan:
- Single write: push addr 24'h000040, data 32'h00000ABC, strb 4'hF with awready=wready=1 and bvalid returned next cycle with bresp 00 -> awvalid/wvalid high in cycle N+1 for exactly 1 cycle carrying those values; bready high for 1 cycle; busy returns to 0; err_count=0.
- Split handshake: hold wready=0 for 3 cycles while awready=1 -> awvalid drops after 1 cycle; wvalid stays high with data 32'h12345678 unchanged until wready; RESP is entered only after the W handshake.
- Backpressure/full: hold awready=0 and push 6 requests with DEPTH=4 -> 1 request in flight, 4 buffered, req_ready=0 on the 6th; on release all 5 writes emerge in order with addresses 0,4,8,C,10.
- Error response: bresp=2'b10 on 3 writes, then 2'b00 -> err_count=3. With ERR_WIDTH=2 and 5 errors -> err_count saturates at 3.
- Async reset mid-ADDR_DATA with 2 requests queued: assert rst low between clock edges -> awvalid/wvalid/busy drop to 0 immediately; after release no AXI activity occurs until a new push.
- Timeout (macro defined): awready held 0 for 65535 cycles -> awvalid drops, err_count=1, next queued request issues.
